// File: rtl/cpu6_csr.sv
// Machine-mode CSR file for cpu6: trap capture, mret restore, CSRRW/S/C access,
// and the mcycle/minstret counters.
module cpu6_csr #(
  parameter int              XLEN        = 64,
  parameter logic [XLEN-1:0] RESET_MTVEC = '0,
  parameter logic [XLEN-1:0] MISA_VAL    = XLEN'(64'h8000_0000_0000_0100)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [11:0]     csr_rd_addr,
  output logic [XLEN-1:0] csr_rd_data,
  input  logic            csr_wr_ena,
  input  logic [1:0]      csr_wr_op,
  input  logic [11:0]     csr_wr_addr,
  input  logic [XLEN-1:0] csr_wr_data,
  output logic            csr_illegal,
  input  logic [XLEN-1:0] excp_mepc,
  input  logic            excp_mepc_ena,
  input  logic [XLEN-1:0] excp_mcause,
  input  logic            mret,
  input  logic            instr_retire,
  output logic [XLEN-1:0] csr_mtvec,
  output logic [XLEN-1:0] csr_mepc,
  output logic            csr_mie
);

  localparam logic [11:0] A_MSTATUS  = 12'h300;
  localparam logic [11:0] A_MISA     = 12'h301;
  localparam logic [11:0] A_MTVEC    = 12'h305;
  localparam logic [11:0] A_MSCRATCH = 12'h340;
  localparam logic [11:0] A_MEPC     = 12'h341;
  localparam logic [11:0] A_MCAUSE   = 12'h342;
  localparam logic [11:0] A_MCYCLE   = 12'hB00;
  localparam logic [11:0] A_MINSTRET = 12'hB02;
  localparam logic [11:0] A_MHARTID  = 12'hF14;

  localparam logic [XLEN-1:0] MTVEC_RST = {RESET_MTVEC[XLEN-1:2], 2'b00};

  logic            mie_q, mie_d;
  logic            mpie_q, mpie_d;
  logic [XLEN-1:0] mtvec_q, mtvec_d;
  logic [XLEN-1:0] mscratch_q, mscratch_d;
  logic [XLEN-1:0] mepc_q, mepc_d;
  logic [XLEN-1:0] mcause_q, mcause_d;
  logic [XLEN-1:0] mcycle_q, mcycle_d;
  logic [XLEN-1:0] minstret_q, minstret_d;

  logic [XLEN-1:0] mstatus_val;
  logic [XLEN-1:0] wr_old;
  logic [XLEN-1:0] wr_new;
  logic            wr_hit;
  logic            wr_writable;
  logic            wr_do;
  logic            rd_hit;

  always_comb begin
    mstatus_val        = '0;
    mstatus_val[12:11] = 2'b11;
    mstatus_val[7]     = mpie_q;
    mstatus_val[3]     = mie_q;
  end

  // Returns {implemented, current value}; shared by the read port and the RMW path.
  function automatic logic [XLEN:0] lookup(input logic [11:0] a);
    logic [XLEN:0] r;
    case (a)
      A_MSTATUS:  r = {1'b1, mstatus_val};
      A_MISA:     r = {1'b1, MISA_VAL};
      A_MTVEC:    r = {1'b1, mtvec_q};
      A_MSCRATCH: r = {1'b1, mscratch_q};
      A_MEPC:     r = {1'b1, mepc_q};
      A_MCAUSE:   r = {1'b1, mcause_q};
      A_MCYCLE:   r = {1'b1, mcycle_q};
      A_MINSTRET: r = {1'b1, minstret_q};
      A_MHARTID:  r = {1'b1, {XLEN{1'b0}}};
      default:    r = '0;
    endcase
    return r;
  endfunction

  always_comb begin
    {rd_hit, csr_rd_data} = lookup(csr_rd_addr);
    {wr_hit, wr_old}      = lookup(csr_wr_addr);
    wr_writable = wr_hit && (csr_wr_addr != A_MISA) && (csr_wr_addr != A_MHARTID);
    wr_do       = csr_wr_ena && wr_writable && (csr_wr_op != 2'b00);
    csr_illegal = !rd_hit || (csr_wr_ena && !wr_writable);
    case (csr_wr_op)
      2'b01:   wr_new = csr_wr_data;
      2'b10:   wr_new = wr_old | csr_wr_data;
      2'b11:   wr_new = wr_old & ~csr_wr_data;
      default: wr_new = wr_old;
    endcase
  end

  always_comb begin
    mie_d      = mie_q;
    mpie_d     = mpie_q;
    mtvec_d    = mtvec_q;
    mscratch_d = mscratch_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    mcycle_d   = mcycle_q + XLEN'(1);
    minstret_d = minstret_q + XLEN'(instr_retire);

    // A trap flushes the instruction but does not stop these updates.
    if (wr_do) begin
      case (csr_wr_addr)
        A_MTVEC:    mtvec_d    = {wr_new[XLEN-1:2], 2'b00};
        A_MSCRATCH: mscratch_d = wr_new;
        A_MCYCLE:   mcycle_d   = wr_new;
        A_MINSTRET: minstret_d = wr_new;
        default: ;
      endcase
    end

    if (excp_mepc_ena) begin
      mepc_d   = {excp_mepc[XLEN-1:1], 1'b0};
      mcause_d = excp_mcause;
      mpie_d   = mie_q;
      mie_d    = 1'b0;
    end else if (mret) begin
      mie_d  = mpie_q;
      mpie_d = 1'b1;
    end else if (wr_do) begin
      case (csr_wr_addr)
        A_MSTATUS: begin
          mie_d  = wr_new[3];
          mpie_d = wr_new[7];
        end
        A_MEPC:   mepc_d   = {wr_new[XLEN-1:1], 1'b0};
        A_MCAUSE: mcause_d = wr_new;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mie_q      <= 1'b0;
      mpie_q     <= 1'b0;
      mtvec_q    <= MTVEC_RST;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mcycle_q   <= '0;
      minstret_q <= '0;
    end else begin
      mie_q      <= mie_d;
      mpie_q     <= mpie_d;
      mtvec_q    <= mtvec_d;
      mscratch_q <= mscratch_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
      mcycle_q   <= mcycle_d;
      minstret_q <= minstret_d;
    end
  end

  assign csr_mtvec = mtvec_q;
  assign csr_mepc  = mepc_q;
  assign csr_mie   = mie_q;

endmodule

// File: doc/cpu6_csr.md
Name: cpu6_csr

Overview:
Machine-mode CSR file for cpu6. It sits directly downstream of the exception block. It captures the trap PC and cause when an exception is taken, and supplies mtvec back as the trap target. It also serves CSRRW/CSRRS/CSRRC reads and writes from the execute stage, implements mret state restore, and runs the mcycle and minstret counters.

Parameters:
XLEN, 64, data width; equals the core's CPU6_XLEN.
RESET_MTVEC, 64'h0, reset value of mtvec; bits [1:0] are ignored and forced to 0.
MISA_VAL, 64'h8000000000000100, read-only misa contents (RV64I).

Ports:
clk  input  1  core clock
reset  input  1  asynchronous, active-high reset
csr_rd_addr  input  12  CSR read address
csr_rd_data  output  XLEN  read data, combinational from csr_rd_addr
csr_wr_ena  input  1  write request, qualified for one cycle
csr_wr_op  input  2  01 = write, 10 = set bits, 11 = clear bits, 00 = no-op
csr_wr_addr  input  12  CSR write address
csr_wr_data  input  XLEN  write operand (rs1 value or zimm zero-extended)
csr_illegal  output  1  combinational; high if csr_rd_addr is unimplemented, or csr_wr_ena is set and csr_wr_addr is read-only or unimplemented
excp_mepc  input  XLEN  faulting PC from the exception block
excp_mepc_ena  input  1  trap taken this cycle
excp_mcause  input  XLEN  cause code; 2 = illegal instruction
mret  input  1  mret committing this cycle
instr_retire  input  1  one instruction retired this cycle
csr_mtvec  output  XLEN  trap vector base, to the exception block
csr_mepc  output  XLEN  mret return target, to fetch
csr_mie  output  1  mstatus.MIE, global interrupt enable

Behaviour:
- Implemented CSRs:
  - mstatus 0x300: MIE bit 3 and MPIE bit 7 are read/write; MPP bits 12:11 are hardwired to 2'b11; all other bits read 0.
  - misa 0x301: read-only, returns MISA_VAL.
  - mtvec 0x305: bits [1:0] read 0 (direct mode only).
  - mscratch 0x340: full read/write.
  - mepc 0x341: bit 0 reads 0.
  - mcause 0x342: full read/write.
  - mcycle 0xB00, minstret 0xB02: read/write.
  - mhartid 0xF14: read-only, returns 0.
  - Any other address reads 0 and asserts csr_illegal.
- Reset, asynchronous: mstatus = 0x1800, mtvec = RESET_MTVEC with bits [1:0] cleared, all other registers = 0. Consequently csr_mtvec = RESET_MTVEC & ~3, csr_mepc = 0, csr_mie = 0.
- Read path: combinational and returns the current register value. A write becomes visible the cycle after it.
- Write path: the new value is computed from the old register value before any same-cycle counter increment:
  - op 01: new = data
  - op 10: new = old | data
  - op 11: new = old & ~data
  - op 00: no-op
  - Field masks (hardwired and read-only bits) are applied after the operation.
  - A write to a read-only or unimplemented address is dropped and csr_illegal is raised. The exception block then takes the trap.
- Trap capture (excp_mepc_ena = 1), applied at the next clock edge:
  - mepc <= excp_mepc with bit 0 cleared
  - mcause <= excp_mcause
  - MPIE <= MIE
  - MIE <= 0
- mret, applied at the next clock edge:
  - MIE <= MPIE
  - MPIE <= 1
  - csr_mepc is always driven and valid every cycle.
- Counters:
  - mcycle increments by 1 every cycle; minstret increments when instr_retire is high.
  - Both wrap from all-ones to 0 with no flag.
- Same-cycle priority, highest first: excp_mepc_ena, then mret, then csr_wr_ena. The lower-priority update to mstatus, mepc, or mcause is discarded.
  - A CSR write to a counter in the same cycle as its increment: the written value wins and no increment is applied that cycle.
  - A trap does not block counter increments or writes to mtvec or mscratch, because the exception block flushes the instruction.
- excp_mepc_ena and mret in the same cycle: the trap wins and mret is ignored.
- Reset asserted mid-operation: every register returns to its reset value immediately, with no clock edge required.

Test Plan:
- Reset: assert reset while clk is stopped. Required: csr_mtvec = RESET_MTVEC & ~3, csr_rd_data at 0x300 = 0x1800, mcycle = 0, csr_mie = 0.
- Write/set/clear: write mscratch = 0xF0, then set 0x0F, then clear 0x3C. Required reads: 0xF0, then 0xFF, then 0xC3. A write of 0x1003 to mtvec reads back 0x1000.
- Trap capture: set MIE, then pulse excp_mepc_ena with pc = 0x8000_0105 and cause = 2. Required next cycle: mepc = 0x8000_0104, mcause = 2, mstatus = 0x1880, csr_mie = 0.
- mret after the trap: pulse mret. Required next cycle: mstatus = 0x1888 and csr_mepc = 0x8000_0104. With mret and excp_mepc_ena in the same cycle, the trap update wins.
- Counters:
  - Write mcycle = all-ones. Required: reads 0 two cycles later.
  - Hold instr_retire for 5 cycles. Required: minstret = 5.
  - Write minstret in the same cycle as a retire. Required: the written value holds.
- Illegal access: read 0x7C0, or write misa. Required: csr_illegal = 1, read data = 0, misa unchanged.
